fifo_tx_arbiter: RTL and testbench

- Read-side scheduler on the clk_tx domain. It shares one UART transmitter between two CDC FIFOs: source 0 is the rx-echo FIFO and source 1 is the message/status FIFO.
- It pops bytes through each FIFO's rd_en/empty/data_out interface. FIFO data_out is registered and valid the cycle after rd_en.
- Bytes are presented to the transmitter on a valid/ready handshake.
- Arbitration is round-robin with a bounded burst per grant.

---
 rtl/fifo_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_tx_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_arbiter.sv
// Round-robin read scheduler sharing one UART TX between two CDC FIFOs, with bounded bursts per grant.
// Optional per-source accepted-byte counters are enabled by defining FIFO_TX_ARB_STATS_EN.
module fifo_tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                  clk_tx,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  empty0,
  output logic                  rd_en0,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic                  empty1,
  output logic                  rd_en1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [1:0]            grant,
  output logic                  busy
`ifdef FIFO_TX_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [15:0]           stat_cnt0,
  output logic [15:0]           stat_cnt1
`endif
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d, burst_inc;
  logic                  last_src_q, last_src_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  pick1, granted_empty;

  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      last_src_q  <= 1'b1;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      last_src_q  <= last_src_d;
      tx_data_q   <= tx_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    burst_cnt_d   = burst_cnt_q;
    last_src_d    = last_src_q;
    tx_data_d     = tx_data_q;
    burst_inc     = burst_cnt_q + CW'(1);
    granted_empty = grant_q[1] ? empty1 : empty0;
    // Source 1 wins if it is the fairer choice and non-empty, or if source 0 has nothing.
    pick1         = last_src_q ? empty0 : !empty1;
    unique case (state_q)
      IDLE: begin
        if (enable && (!empty0 || !empty1)) begin
          grant_d     = pick1 ? 2'b10 : 2'b01;
          burst_cnt_d = '0;
          state_d     = POP;
        end
      end
      POP:  state_d = LOAD;
      LOAD: begin
        tx_data_d = grant_q[1] ? data1 : data0;
        state_d   = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          burst_cnt_d = burst_inc;
          if ((burst_inc < BMAX) && enable && !granted_empty) begin
            state_d = POP;
          end else begin
            last_src_d = grant_q[1];
            grant_d    = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en0   = (state_q == POP) && grant_q[0];
  assign rd_en1   = (state_q == POP) && grant_q[1];
  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);

`ifdef FIFO_TX_ARB_STATS_EN
  logic [15:0] stat0_q, stat0_d, stat1_q, stat1_d;
  logic        accept;

  assign accept = (state_q == SEND) && tx_ready;

  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (stat_clr) begin
      stat0_d = '0;
      stat1_d = '0;
    end else if (accept) begin
      if (grant_q[0] && (stat0_q != '1)) stat0_d = stat0_q + 16'd1;
      if (grant_q[1] && (stat1_q != '1)) stat1_d = stat1_q + 16'd1;
    end
  end

  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat_cnt0 = stat0_q;
  assign stat_cnt1 = stat1_q;
`endif

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Scoreboard bench for fifo_tx_arbiter: FIFO models feed the DUT, a round-robin/burst reference
// model predicts the (source, byte) order, and a negedge monitor checks every accepted byte.
module tb_fifo_tx_arbiter;
  localparam int DW = 8;
  localparam int BM = 4;

  logic          clk_tx = 1'b0;
  logic          rst_n, enable, tx_ready;
  logic          empty0, empty1, rd_en0, rd_en1, tx_valid, busy;
  logic [DW-1:0] data0, data1, tx_data;
  logic [1:0]    grant;
`ifdef FIFO_TX_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_cnt0, stat_cnt1;
`endif

  fifo_tx_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk_tx(clk_tx), .rst_n(rst_n), .enable(enable),
    .empty0(empty0), .rd_en0(rd_en0), .data0(data0),
    .empty1(empty1), .rd_en1(rd_en1), .data1(data1),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
`ifdef FIFO_TX_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  always #5 clk_tx = ~clk_tx;

  // FIFO models: registered data_out, valid the cycle after rd_en.
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  int unsigned   wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  assign empty0 = (rp0 == wp0);
  assign empty1 = (rp1 == wp1);
  always @(posedge clk_tx) begin
    if (rd_en0) begin data0 <= mem0[rp0 % 256]; rp0 <= rp0 + 1; end
    if (rd_en1) begin data1 <= mem1[rp1 % 256]; rp1 <= rp1 + 1; end
  end

  // Reference model state and scoreboard.
  logic [DW-1:0] mq0[$], mq1[$];
  logic [DW:0]   sb[$];
  logic          mlast = 1'b1;

  int pass_cnt = 0, chk_cnt = 0;
  int cyc = 0, rd_pulses = 0, n_acc = 0;
  int rd_times[$];
  logic rdy_rand = 1'b0, rdy_val = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_tx);
    #2;
  endtask

  task automatic push(input int s, input logic [DW-1:0] b);
    if (s == 0) begin mem0[wp0 % 256] = b; wp0++; mq0.push_back(b); end
    else        begin mem1[wp1 % 256] = b; wp1++; mq1.push_back(b); end
  endtask

  // Drain both queues in grant order: alternate away from the last owner, up to BM bytes per grant.
  task automatic model_run();
    while (mq0.size() > 0 || mq1.size() > 0) begin
      int s;
      s = mlast ? ((mq0.size() > 0) ? 0 : 1) : ((mq1.size() > 0) ? 1 : 0);
      for (int i = 0; i < BM; i++) begin
        if (s == 0 && mq0.size() > 0) sb.push_back({1'b0, mq0.pop_front()});
        if (s == 1 && mq1.size() > 0) sb.push_back({1'b1, mq1.pop_front()});
      end
      mlast = (s == 1);
    end
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 3000) begin step(); k++; end
    chk({nm, "_drained"}, {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
    chk({nm, "_fifos_empty"}, {30'd0, empty0, empty1}, 32'd3);
    chk({nm, "_grant_idle"}, {30'd0, grant}, 32'd0);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!tx_valid && k < 50) begin step(); k++; end
    chk({nm, "_valid"}, {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    mlast = 1'b1;
  endtask

  always @(posedge clk_tx) cyc++;

  always @(posedge clk_tx) begin
    #1;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Monitor: sampled on the falling edge, the accept happens on the following rising edge.
  logic          prev_rd0 = 1'b0, prev_rd1 = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk_tx) begin
    if (rst_n) begin
      if (rd_en0 || rd_en1) begin
        rd_pulses++;
        rd_times.push_back(cyc);
        chk("rd_both", {31'd0, rd_en0 & rd_en1}, 32'd0);
        chk("rd_on_empty", {31'd0, rd_en0 ? empty0 : empty1}, 32'd0);
        chk("rd_single_cycle", {30'd0, prev_rd0 & rd_en0, prev_rd1 & rd_en1}, 32'd0);
      end
      if (prev_stall) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        logic [DW:0] e;
        n_acc++;
        if (sb.size() == 0) begin
          chk_cnt++;
          $display("FAIL sb_underflow: accepted byte %0h with nothing expected", tx_data);
        end else begin
          e = sb.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, e[DW-1:0]});
          chk("tx_grant", {30'd0, grant}, e[DW] ? 32'd2 : 32'd1);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_rd0   = rd_en0;
      prev_rd1   = rd_en1;
    end else begin
      prev_stall = 1'b0;
      prev_rd0   = 1'b0;
      prev_rd1   = 1'b0;
    end
  end

  initial begin
    int k, base_rd, base_acc;
    // Reset held with random inputs; FIFO 0 loaded meanwhile.
    rst_n = 1'b0; enable = 1'b0; rdy_rand = 1'b1;
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    for (int i = 0; i < 5; i++) begin
      enable = 1'($urandom_range(0, 1));
      step();
      chk("rst_outputs", {20'd0, tx_valid, tx_data, rd_en0, rd_en1, grant, busy}, 32'd0);
    end
    enable = 1'b0; rdy_rand = 1'b0; rdy_val = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("rst_release_rd", {30'd0, rd_en0, rd_en1}, 32'd0);
    step(); step();
    chk("disabled_idle", {30'd0, busy, rd_en0}, 32'd0);

    // Single source, 3-cycle latency and 3-cycle pop spacing.
    model_run();
    rd_times.delete();
    enable = 1'b1;
    k = 0;
    while (!tx_valid && k < 20) begin step(); k++; end
    chk("latency", k, 32'd3);
    wait_drain("single");
    chk("single_rd_count", rd_times.size(), 32'd3);
    if (rd_times.size() == 3) begin
      chk("single_rd_gap1", rd_times[1] - rd_times[0], 32'd3);
      chk("single_rd_gap2", rd_times[2] - rd_times[1], 32'd3);
    end

    // Round-robin with bursts from reset.
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin push(0, 8'(i)); push(1, 8'(8'h10 + i)); end
    model_run();
    rdy_rand = 1'b1;
    enable = 1'b1;
    wait_drain("rr");
`ifdef FIFO_TX_ARB_STATS_EN
    chk("stat_cnt0", {16'd0, stat_cnt0}, 32'd6);
    chk("stat_cnt1", {16'd0, stat_cnt1}, 32'd6);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stat_clr", {stat_cnt0, stat_cnt1}, 32'd0);
`endif

    // Backpressure: byte held for 5 stalled cycles, single accept.
    enable = 1'b0; rdy_rand = 1'b0; rdy_val = 1'b0;
    step(); step();
    push(1, 8'h5A);
    model_run();
    enable = 1'b1;
    wait_valid("bp");
    base_rd = rd_pulses;
    base_acc = n_acc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {23'd0, tx_valid, tx_data}, 32'h15A);
    end
    chk("bp_no_rd", rd_pulses - base_rd, 32'd0);
    rdy_val = 1'b1;
    step();
    rdy_val = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bp_one_accept", n_acc - base_acc, 32'd1);
    wait_drain("bp");

    // Enable dropped during SEND of the 2nd byte of a 4-byte burst.
    enable = 1'b0; rdy_val = 1'b1;
    step(); step();
    for (int i = 0; i < 4; i++) push(0, 8'(8'hB0 + i));
    sb.push_back({1'b0, mq0.pop_front()});
    sb.push_back({1'b0, mq0.pop_front()});
    base_acc = n_acc;
    enable = 1'b1;
    k = 0;
    while (n_acc != base_acc + 1 && k < 50) begin step(); k++; end
    wait_valid("en_drop");
    enable = 1'b0;
    base_rd = rd_pulses;
    for (int i = 0; i < 6; i++) step();
    chk("en_drop_no_rd", rd_pulses - base_rd, 32'd0);
    chk("en_drop_accepts", n_acc - base_acc, 32'd2);
    chk("en_drop_idle", {29'd0, grant, busy}, 32'd0);
    mlast = 1'b0;
    model_run();
    enable = 1'b1;
    wait_drain("en_resume");

    // Randomized loads with random backpressure.
    for (int r = 0; r < 6; r++) begin
      int n0, n1;
      enable = 1'b0;
      step();
      n0 = $urandom_range(0, 9);
      n1 = $urandom_range(0, 9);
      for (int i = 0; i < n0; i++) push(0, 8'($urandom));
      for (int i = 0; i < n1; i++) push(1, 8'($urandom));
      model_run();
      rdy_rand = 1'b1;
      enable = 1'b1;
      wait_drain("rand");
    end

    // Reset while a popped byte waits in SEND: it is discarded.
    rdy_rand = 1'b0; rdy_val = 1'b0;
    step(); step();
    push(1, 8'hEE);
    enable = 1'b1;
    wait_valid("discard");
    chk("discard_data", {24'd0, tx_data}, 32'hEE);
    rst_n = 1'b0;
    #1;
    chk("discard_rst", {20'd0, tx_valid, tx_data, grant, busy, rd_en1}, 32'd0);
    step();
    rst_n = 1'b1;
    mq1.delete();
    mlast = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("discard_idle", {31'd0, busy}, 32'd0);
    chk("sb_empty_end", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
